// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared types and constants for the instruction-fetch path:
//           sequencer state encoding, data width, default halt encoding and
//           the {pc, instr} entry carried through the fetch queue.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int XLEN = 32;

    // Default encoding of the instruction that stops fetching.
    localparam logic [XLEN-1:0] DEFAULT_HALT_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_queue2.sv
// ============================================================================
// Module  : fetch_queue2
// Purpose : Two-entry synchronous FIFO of fetch entries.
// Ports   : clk          - rising-edge clock
//           reset        - asynchronous active-low reset
//           push_i       - enqueue push_entry_i (ignored when full w/o pop)
//           push_entry_i - entry to enqueue
//           pop_i        - dequeue head (ignored when empty)
//           flush_i      - discard all entries; wins over push and pop
//           count_o      - number of stored entries (0..2)
//           valid_o      - queue holds at least one entry
//           head_o       - oldest entry
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue2
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output logic         valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    logic [1:0]   count_q, count_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        // A full queue still accepts a push when the head leaves this cycle.
        do_push  = push_i && ((count_q != 2'd2) || do_pop) && !flush_i;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
        rd_ptr_d = rd_ptr_q ^ do_pop;
        wr_ptr_d = wr_ptr_q ^ do_push;
        if (flush_i) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule : fetch_queue2

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module  : fetch_sequencer
// Purpose : Instruction-fetch control. Owns the PC, addresses a 16-word
//           combinational instruction memory, and buffers {pc, instr}
//           pairs toward decode through a 2-entry valid/ready queue.
//           Handles start, redirect with flush, and halt on HALT_INSTR.
// Ports   : clk            - rising-edge clock
//           reset          - asynchronous active-low reset
//           start          - pulse: leave IDLE and begin fetching
//           imem_addr      - word address = fetch_pc[MEM_AW+1:2]
//           imem_rdata     - instruction for imem_addr, same cycle
//           fetch_pc       - current PC register
//           out_valid      - queue head valid
//           out_ready      - decode accepts head
//           out_instr      - head instruction
//           out_pc         - head byte address
//           redirect_valid - redirect request (any state)
//           redirect_pc    - redirect target byte address
//           halted         - high in HALT state
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_AW     = 4,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [MEM_AW-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       fetch_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted
);

    state_t       state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         push, pop;
    logic [1:0]   count;
    fetch_entry_t push_entry, head;

    assign pop = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (redirect_valid) begin
            // Redirect beats everything; an IDLE sequencer only takes the PC.
            pc_d    = redirect_pc & ~32'h0000_0003;
            state_d = (state_q == IDLE) ? IDLE : RUN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if ((count != 2'd2) || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                        if (imem_rdata == HALT_INSTR) begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = imem_rdata;

    fetch_queue2 u_queue (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (count),
        .valid_o      (out_valid),
        .head_o       (head)
    );

    assign imem_addr = pc_q[MEM_AW+1:2];
    assign fetch_pc  = pc_q;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign halted    = (state_q == HALT);

endmodule : fetch_sequencer

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block for the instruction-fetch path. It owns the program counter and the +4 increment, drives the word address into the 16-word combinational instruction memory, and buffers fetched {pc, instruction} pairs in a 2-entry queue toward decode using a valid/ready handshake. It also handles start, branch/jump redirect with flush, and halt on a designated instruction, so the fetch loop runs only when downstream can accept.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_AW, 4, instruction-memory word-address width (16 words).
HALT_INSTR, 32'h0000_0073, instruction encoding that stops fetching once enqueued.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  one-cycle pulse; leaves IDLE and begins fetching
imem_addr  out  MEM_AW  word address to instruction memory = fetch_pc[MEM_AW+1:2]
imem_rdata  in  32  instruction from memory, combinational in the same cycle as imem_addr
fetch_pc  out  32  current PC register
out_valid  out  1  head of queue holds a valid instruction
out_ready  in  1  decode accepts the head this cycle
out_instr  out  32  instruction at queue head
out_pc  out  32  byte address of out_instr
redirect_valid  in  1  one-cycle redirect request from execute
redirect_pc  in  32  redirect target (byte address)
halted  out  1  high while in HALT state

Behaviour:
- States: IDLE, RUN, HALT. Reset (async, active-low) forces IDLE, pc=RESET_PC, queue count=0, out_valid=0, halted=0, out_instr=0, out_pc=0.
- IDLE: no fetch. start=1 -> RUN next cycle. start in RUN/HALT is ignored.
- RUN: push allowed when count<2, or when count==2 and a pop happens this cycle. On push: enqueue {pc, imem_rdata}; pc<=pc+4 (mod 2^32). No push -> pc holds (stall).
- Pop: out_valid && out_ready. Push and pop in the same cycle keep count unchanged. Order is strictly FIFO.
- Halt: if the pushed imem_rdata == HALT_INSTR, the halt word is enqueued, pc<=pc+4, and the state goes to HALT next cycle. In HALT there are no pushes. The queue keeps draining normally, and halted=1.
- Redirect (highest priority, any state): queue flushed (count=0, out_valid=0 next cycle); pc<=redirect_pc with bits[1:0] forced to 0. No push that cycle, even if a pop occurs. If in RUN or HALT -> RUN. If in IDLE -> stays IDLE, with the PC updated.
- Redirect coincident with a pop: the pop handshake completes (decode consumed the head); the flush still applies.
- Address wrap: imem_addr uses pc[5:2], so byte address 64 aliases to word 0. The PC itself keeps counting in 32 bits; 32'hFFFF_FFFC+4 wraps to 0.
- Latency: an instruction at pc is visible on out_instr one cycle after the push edge when the queue was empty.
- Output stability: while out_valid=1 and out_ready=0, out_instr and out_pc are held constant.
- Reset mid-operation: the queue content is discarded immediately; outputs go to their reset values asynchronously.

Decomposition:
- Shared package fetch_pkg: state enum {IDLE, RUN, HALT}; XLEN=32; default HALT_INSTR; fetch-entry struct {pc[31:0], instr[31:0]}.
- One sub-module: fetch_queue2, a 2-entry synchronous FIFO of fetch entries with push, pop, flush, count, head outputs, and the same clk/reset. Flush has priority over push.

Test Plan:
- Reset release, start pulse, out_ready=1, memory words 0..3 = 0x11,0x22,0x33,0x44 -> out_instr 0x11,0x22,0x33,0x44 on consecutive cycles; out_pc 0,4,8,12.
- out_ready=0 for 5 cycles after start -> count saturates at 2; fetch_pc stops at 8; out_instr=word0 held. Release ready -> words 0,1,2 in order with no loss or duplication.
- Redirect to 0x2A while the queue is full -> out_valid=0 next cycle; next instruction delivered is word 10 with out_pc=0x28; the 0x2A low bits are cleared.
- Word 3 = HALT_INSTR -> words 0..3 delivered, halted=1, and fetch_pc frozen at 16. A later redirect to 0 resumes RUN from word 0.
- Run 20 sequential fetches from reset -> imem_addr wraps 15->0 at pc=64 while out_pc=64.
- Assert reset low mid-stream with count=2 -> out_valid=0 and fetch_pc=RESET_PC immediately; after release, state is IDLE and there is no fetch until start.
